uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (din/enable/ready interface, 8N1, ready low while shifting) between NUM_REQ byte-stream requesters. Round-robin arbitration with packet locking: a granted requester keeps the transmitter until it sends a byte flagged last. Sits between application threads (e.g. LED/switch echo, status reporter) and the single transmitter instance in the board top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width (fixed 8 for the UART)
ACK_TIMEOUT, 15, max cycles to wait for tx_ready to fall after an enable pulse
ID_WIDTH, 2, width of grant_id, equal to clog2(NUM_REQ)

Ports:
clk  in  1  clock
RST  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*8  packed bytes; requester i is [8i+7:8i]
req_last  in  NUM_REQ  byte is the final byte of the packet
req_ready  out  NUM_REQ  byte accepted this cycle (combinational, one-hot or zero)
tx_din  out  8  byte to transmitter (registered)
tx_enable  out  1  one-cycle start pulse to transmitter (registered)
tx_ready  in  1  transmitter idle
grant_id  out  ID_WIDTH  current or last owner
locked  out  1  a packet is in progress
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on ack timeout

Behaviour:
- Reset values: tx_din=0, tx_enable=0, grant_id=0, locked=0, busy=0, timeout_err=0, rr pointer=0 (requester 0 has highest priority first), state=IDLE.
- States: IDLE, ISSUE_WAIT (WAIT_ACK), WAIT_DONE.
- IDLE: eligible set = req_valid masked to owner only when locked, else all. If tx_ready=1 and eligible nonzero: winner = first set bit searching from rr pointer upward, wrapping. Same cycle req_ready[winner]=1, tx_din<=byte, tx_enable<=1, grant_id<=winner, last_flag<=req_last[winner], ack counter<=0 -> WAIT_ACK. If tx_ready=0 in IDLE: no accept, stay.
- Locked with owner req_valid=0: stall in IDLE; other requesters are not granted.
- WAIT_ACK: tx_enable<=0 (pulse exactly 1 cycle). tx_ready=0 -> WAIT_DONE. Else counter++; when counter reaches ACK_TIMEOUT: timeout_err<=1, locked<=0, rr pointer<=owner+1, -> IDLE.
- WAIT_DONE: wait tx_ready=1 -> IDLE. On exit: if last_flag: locked<=0, rr pointer<=owner+1 mod NUM_REQ; else locked<=1 (owner retained).
- Latency: accept at cycle T, tx_enable high T+1, earliest next accept when tx_ready returns high in WAIT_DONE, plus 1 cycle.
- req_ready is never asserted outside IDLE. At most one bit is set.
- rr pointer wraps from NUM_REQ-1 to 0. Pointer is unchanged between bytes of a locked packet.
- Single-byte packets (last=1 on first byte) never set locked.
- Reset mid-transfer: all state returns to reset values immediately. tx_enable drops. The transmitter is reset by the same RST.
- timeout_err clears only on RST.

Decomposition:
- Shared package: state encoding constants (IDLE=0, WAIT_ACK=1, WAIT_DONE=2), ACK_TIMEOUT default, byte width constant.
- One sub-module: rr_priority_pick. Combinational: request vector plus pointer -> one-hot grant and index. Reusable by other arbiters in the design.

Test Plan:
- Single request: req_valid=0001, data=0x41, last=1, tx_ready stub falls 1 cycle after enable and rises 10 cycles later -> req_ready=0001 for one cycle, tx_din=0x41, one enable pulse, locked stays 0, pointer=1.
- Contention: all four valid, single-byte packets, continuous -> grants in order 0,1,2,3,0. Each grant_id appears once per rotation.
- Packet lock: req0 sends 0x10,0x11,0x12 (last on 0x12) while req1 is valid throughout -> req1 is granted only after 0x12 completes. Also stall requester 0 for 5 cycles mid-packet -> no grant to req1 during the stall.
- Timeout: tx_ready held at 1 after enable -> timeout_err=1 after 15 cycles, state returns to IDLE, lock released, next requester is served.
- Back-pressure: tx_ready=0 at entry with req valid -> no req_ready and no enable until tx_ready=1.
- Reset mid-transfer: assert RST in WAIT_DONE with locked=1 -> next cycle all outputs are at reset values. After release, req0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_pkg
// Brief    : Shared constants for the UART transmit arbiter slice.
// Revision : 1.0
// ============================================================================
package uart_tx_arbiter_pkg;

  localparam int c_DATA_WIDTH  = 8;
  localparam int c_ACK_TIMEOUT = 15;

  localparam int              c_STATE_W       = 2;
  localparam logic [1:0]      c_ST_IDLE       = 2'd0;
  localparam logic [1:0]      c_ST_WAIT_ACK   = 2'd1;
  localparam logic [1:0]      c_ST_WAIT_DONE  = 2'd2;

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side byte streams plus transmitter handshake.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_din;
  logic                          tx_enable;
  logic                          tx_ready;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          locked;
  logic                          busy;
  logic                          timeout_err;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_din, tx_enable, grant_id, locked, busy, timeout_err
  );

  // Requesters and transmitter side
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_din, tx_enable, grant_id, locked, busy, timeout_err
  );
endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin pick: first request at or after i_ptr.
// Revision : 1.0
// ============================================================================
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  wire logic [N-1:0]     i_req,
  input  wire logic [IDX_W-1:0] i_ptr,
  output logic      [N-1:0]     o_grant,
  output logic      [IDX_W-1:0] o_idx,
  output logic                  o_any
);

  logic [IDX_W:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      // Extra bit holds ptr+k before the modulo-N wrap
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N)) begin
        w_pos = w_pos - (IDX_W+1)'(N);
      end
      if (!o_any && i_req[w_pos[IDX_W-1:0]]) begin
        o_any                     = 1'b1;
        o_grant[w_pos[IDX_W-1:0]] = 1'b1;
        o_idx                     = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking share of one 8N1 UART transmitter.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = c_DATA_WIDTH,
  parameter int ACK_TIMEOUT = c_ACK_TIMEOUT,
  parameter int ID_WIDTH    = 2
) (
  input wire logic         clk,
  input wire logic         RST,
  uart_tx_arbiter_if.slave io_arb
);

  localparam int                  c_CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ID_WIDTH-1:0] c_LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic [c_STATE_W-1:0]  r_state;
  logic [c_STATE_W-1:0]  w_state_nxt;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_owner;
  logic                  r_locked;
  logic                  r_last;
  logic [c_CNT_W-1:0]    r_ack_cnt;
  logic [DATA_WIDTH-1:0] r_tx_din;
  logic                  r_tx_en;
  logic                  r_timeout;

  logic [NUM_REQ-1:0]    w_owner_mask;
  logic [NUM_REQ-1:0]    w_eligible;
  logic [NUM_REQ-1:0]    w_pick_grant;
  logic [ID_WIDTH-1:0]   w_pick_idx;
  logic                  w_pick_any;
  logic [DATA_WIDTH-1:0] w_pick_byte;
  logic                  w_pick_last;
  logic                  w_accept;
  logic                  w_ack_timeout;
  logic                  w_done_exit;
  logic [ID_WIDTH-1:0]   w_owner_next;

  // A locked packet masks every other requester, even when the owner stalls
  assign w_owner_mask = NUM_REQ'(1) << r_owner;
  assign w_eligible   = r_locked ? (io_arb.req_valid & w_owner_mask) : io_arb.req_valid;
  assign w_owner_next = (r_owner == c_LAST_ID) ? '0 : r_owner + ID_WIDTH'(1);

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_WIDTH)
  ) u_pick (
    .i_req   (w_eligible),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_pick_byte = '0;
    w_pick_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_grant[i]) begin
        w_pick_byte = io_arb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_pick_last = io_arb.req_last[i];
      end
    end
  end

  assign w_ack_timeout = (r_state == c_ST_WAIT_ACK) && io_arb.tx_ready &&
                         (r_ack_cnt == c_CNT_W'(ACK_TIMEOUT - 1));
  assign w_done_exit   = (r_state == c_ST_WAIT_DONE) && io_arb.tx_ready;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (io_arb.tx_ready && w_pick_any) begin
          w_state_nxt = c_ST_WAIT_ACK;
        end
      end
      c_ST_WAIT_ACK: begin
        if (!io_arb.tx_ready) begin
          w_state_nxt = c_ST_WAIT_DONE;
        end else if (w_ack_timeout) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_WAIT_DONE: begin
        if (io_arb.tx_ready) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept         = (r_state == c_ST_IDLE) && io_arb.tx_ready && w_pick_any;
    io_arb.req_ready = w_accept ? w_pick_grant : '0;
    io_arb.busy      = (r_state != c_ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_locked  <= 1'b0;
      r_last    <= 1'b0;
      r_ack_cnt <= '0;
      r_tx_din  <= '0;
      r_tx_en   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_tx_en <= w_accept;
      if (w_accept) begin
        r_tx_din  <= w_pick_byte;
        r_owner   <= w_pick_idx;
        r_last    <= w_pick_last;
        r_ack_cnt <= '0;
      end else if ((r_state == c_ST_WAIT_ACK) && io_arb.tx_ready) begin
        r_ack_cnt <= r_ack_cnt + c_CNT_W'(1);
      end
      // A lost handshake abandons the packet so the others are not starved
      if (w_ack_timeout) begin
        r_timeout <= 1'b1;
        r_locked  <= 1'b0;
        r_ptr     <= w_owner_next;
      end
      if (w_done_exit) begin
        if (r_last) begin
          r_locked <= 1'b0;
          r_ptr    <= w_owner_next;
        end else begin
          r_locked <= 1'b1;
        end
      end
    end
  end

  assign io_arb.tx_din      = r_tx_din;
  assign io_arb.tx_enable   = r_tx_en;
  assign io_arb.grant_id    = r_owner;
  assign io_arb.locked      = r_locked;
  assign io_arb.timeout_err = r_timeout;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Randomised bench with a queue-based arbitration reference model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  logic clk;
  logic RST;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2)) ifc ();

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (8),
    .ACK_TIMEOUT (15),
    .ID_WIDTH    (2)
  ) dut (
    .clk    (clk),
    .RST    (RST),
    .io_arb (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter stub: drops ready the edge after it sees enable, busy 2..12 cycles
  logic stub_ready;
  int   stub_cnt;
  logic noack;
  logic hold_low;

  always @(posedge clk) begin
    if (RST) begin
      stub_ready <= 1'b1;
      stub_cnt   <= 0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_ready <= 1'b1;
    end else if (ifc.tx_enable && !noack) begin
      stub_ready <= 1'b0;
      stub_cnt   <= $urandom_range(2, 12);
    end
  end

  assign ifc.tx_ready = stub_ready & ~hold_low;

  int n_chk;
  int n_pass;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Requester byte queues: {last, data}
  logic [8:0] mem [4][64];
  int         head [4];
  int         tail [4];
  logic [3:0] stall;
  logic [3:0] vld;
  logic [31:0] dat;
  logic [3:0] lst;

  // Reference model state
  int   m_ptr;
  int   m_owner;
  logic m_locked;
  logic inflight;
  logic seen_low;
  logic prev_acc;
  logic [7:0] prev_byte;
  int   prev_idx;
  int   n_acc;
  int   n_en;
  int   acc_log [$];

  task automatic push(int r, logic [7:0] d, logic l);
    mem[r][tail[r] % 64] = {l, d};
    tail[r]++;
  endtask

  function automatic logic all_empty();
    logic e = 1'b1;
    for (int i = 0; i < 4; i++) if (head[i] != tail[i]) e = 1'b0;
    return e;
  endfunction

  function automatic logic [3:0] f_exp_grant(logic [3:0] v);
    logic [3:0] elig;
    int j;
    elig = v;
    if (m_locked) begin
      elig = 4'b0;
      elig[m_owner] = v[m_owner];
    end
    for (int k = 0; k < 4; k++) begin
      j = (m_ptr + k) % 4;
      if (elig[j]) return 4'(1 << j);
    end
    return 4'b0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_locked = 1'b0;
    inflight = 1'b0; seen_low = 1'b0; prev_acc = 1'b0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
  endtask

  task automatic cycle();
    logic [3:0] rr;
    logic [3:0] exp_rr;
    logic [8:0] ent;
    int idx;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ent = mem[i][head[i] % 64];
      vld[i] = (head[i] != tail[i]) && !stall[i];
      dat[i*8 +: 8] = vld[i] ? ent[7:0] : 8'($urandom);
      lst[i] = vld[i] ? ent[8] : 1'($urandom);
    end
    ifc.req_valid = vld;
    ifc.req_data  = dat;
    ifc.req_last  = lst;
    #1;
    chk("tx_enable", 32'(ifc.tx_enable), 32'(prev_acc));
    if (ifc.tx_enable) n_en++;
    if (prev_acc) begin
      chk("tx_din", 32'(ifc.tx_din), 32'(prev_byte));
      chk("grant_id", 32'(ifc.grant_id), 32'(prev_idx));
    end
    rr = ifc.req_ready;
    if (inflight && !ifc.tx_ready) seen_low = 1'b1;
    exp_rr = (!inflight && ifc.tx_ready) ? f_exp_grant(vld) : 4'b0;
    chk("req_ready", 32'(rr), 32'(exp_rr));
    if (inflight && seen_low && ifc.tx_ready) inflight = 1'b0;
    prev_acc = 1'b0;
    if (rr != 4'b0) begin
      idx = 0;
      for (int i = 3; i >= 0; i--) if (rr[i]) idx = i;
      chk("locked_at_accept", 32'(ifc.locked), 32'(m_locked));
      ent = mem[idx][head[idx] % 64];
      head[idx]++;
      prev_byte = ent[7:0];
      prev_idx  = idx;
      prev_acc  = 1'b1;
      acc_log.push_back(idx);
      n_acc++;
      inflight = 1'b1;
      seen_low = 1'b0;
      if (ent[8]) begin
        m_locked = 1'b0;
        m_ptr    = (idx + 1) % 4;
      end else begin
        m_locked = 1'b1;
        m_owner  = idx;
      end
    end
  endtask

  task automatic drain(string tag, int max);
    int n = 0;
    while ((!all_empty() || inflight) && n < max) begin
      cycle();
      n++;
    end
    chk(tag, 32'(all_empty() && !inflight), 32'd1);
  endtask

  task automatic wait_acc(string tag, int target, int max);
    int n = 0;
    while (n_acc < target && n < max) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n_acc), 32'(target));
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_tx_din"},    32'(ifc.tx_din),      32'd0);
    chk({tag, "_tx_enable"}, 32'(ifc.tx_enable),   32'd0);
    chk({tag, "_grant_id"},  32'(ifc.grant_id),    32'd0);
    chk({tag, "_locked"},    32'(ifc.locked),      32'd0);
    chk({tag, "_busy"},      32'(ifc.busy),        32'd0);
    chk({tag, "_timeout"},   32'(ifc.timeout_err), 32'd0);
  endtask

  initial begin
    int base;
    int k;
    int len;
    logic tseen;
    n_chk = 0; n_pass = 0; n_acc = 0; n_en = 0;
    noack = 1'b0; hold_low = 1'b0; stall = 4'b0;
    ifc.req_valid = '0; ifc.req_data = '0; ifc.req_last = '0;
    model_reset();
    RST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_req_ready", 32'(ifc.req_ready), 32'd0);
    @(negedge clk);
    RST = 1'b0;

    // Single request
    base = acc_log.size();
    k = n_en;
    push(0, 8'h41, 1'b1);
    drain("single_drain", 100);
    chk("single_accepts", 32'(acc_log.size() - base), 32'd1);
    chk("single_enables", 32'(n_en - k), 32'd1);
    chk("single_winner", 32'(acc_log[base]), 32'd0);
    cycle();
    chk("single_unlocked", 32'(ifc.locked), 32'd0);

    // Contention: pointer sits at 1 after the single request
    base = acc_log.size();
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1); push(3, 8'hB3, 1'b1);
    drain("cont_drain", 300);
    chk("cont_order0", 32'(acc_log[base]),   32'd1);
    chk("cont_order1", 32'(acc_log[base+1]), 32'd2);
    chk("cont_order2", 32'(acc_log[base+2]), 32'd3);
    chk("cont_order3", 32'(acc_log[base+3]), 32'd0);
    chk("cont_order4", 32'(acc_log[base+4]), 32'd3);

    // Packet lock with an owner stall mid-packet
    base = acc_log.size();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    push(1, 8'h55, 1'b1);
    wait_acc("lock_two_bytes", n_acc + 2, 100);
    stall[0] = 1'b1;
    k = n_acc;
    repeat (20) cycle();
    chk("lock_stall_no_grant", 32'(n_acc), 32'(k));
    chk("lock_held", 32'(ifc.locked), 32'd1);
    stall[0] = 1'b0;
    drain("lock_drain", 300);
    chk("lock_order2", 32'(acc_log[base+2]), 32'd0);
    chk("lock_order3", 32'(acc_log[base+3]), 32'd1);

    // Back-pressure: transmitter not ready at entry
    hold_low = 1'b1;
    k = n_acc;
    base = n_en;
    push(2, 8'h77, 1'b1);
    repeat (6) cycle();
    chk("bp_no_accept", 32'(n_acc), 32'(k));
    chk("bp_no_enable", 32'(n_en), 32'(base));
    hold_low = 1'b0;
    drain("bp_drain", 100);
    chk("bp_winner", 32'(acc_log[acc_log.size()-1]), 32'd2);

    // Acknowledge timeout on a non-last byte
    noack = 1'b1;
    stall = 4'b1001;
    push(2, 8'hA5, 1'b0);
    push(3, 8'h33, 1'b1);
    push(0, 8'h44, 1'b1);
    wait_acc("to_accept", n_acc + 1, 20);
    tseen = 1'b0;
    k = 0;
    while (!tseen && k < 40) begin
      cycle();
      k++;
      if (k == 13) chk("to_not_early", 32'(ifc.timeout_err), 32'd0);
      tseen = ifc.timeout_err;
    end
    chk("to_set", 32'(tseen), 32'd1);
    chk("to_unlocked", 32'(ifc.locked), 32'd0);
    chk("to_idle", 32'(ifc.busy), 32'd0);
    inflight = 1'b0;
    m_locked = 1'b0;
    m_ptr    = 3;
    noack = 1'b0;
    stall = 4'b0;
    base = acc_log.size();
    drain("to_drain", 200);
    chk("to_next0", 32'(acc_log[base]),   32'd3);
    chk("to_next1", 32'(acc_log[base+1]), 32'd0);
    chk("to_sticky", 32'(ifc.timeout_err), 32'd1);

    // Randomised traffic with random owner stalls
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < int'($urandom_range(2, 4)); p++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
      end
    end
    k = 0;
    while (!all_empty() && k < 3000) begin
      for (int i = 0; i < 4; i++) stall[i] = ($urandom_range(0, 3) == 0);
      cycle();
      k++;
    end
    stall = 4'b0;
    drain("rand_drain", 300);

    // Reset in the middle of a locked packet
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
    wait_acc("rst_two_bytes", n_acc + 2, 100);
    k = 0;
    while (ifc.tx_ready && k < 20) begin cycle(); k++; end
    cycle();
    chk("rst_pre_locked", 32'(ifc.locked), 32'd1);
    chk("rst_pre_busy", 32'(ifc.busy), 32'd1);
    @(negedge clk);
    RST = 1'b1;
    ifc.req_valid = '0;
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    RST = 1'b0;
    model_reset();
    base = acc_log.size();
    push(3, 8'hD3, 1'b1); push(1, 8'hD1, 1'b1); push(0, 8'hD0, 1'b1);
    drain("post_rst_drain", 200);
    chk("post_rst_first", 32'(acc_log[base]),   32'd0);
    chk("post_rst_second", 32'(acc_log[base+1]), 32'd1);
    chk("post_rst_third", 32'(acc_log[base+2]), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
